// File: rtl/lcd_timing_ctrl.sv
// LCD timing controller: divides the system clock into pixel periods, walks a
// raster of active/porch/sync regions, and emits registered sync, data-enable,
// coordinate and fetch strobes. A DRAIN phase lets the current frame finish
// cleanly after the run request is withdrawn.
module lcd_timing_ctrl #(
  parameter int DIV      = 6,
  parameter int H_ACTIVE = 480,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 41,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 272,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 10,
  parameter int V_BP     = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       enable,
  output logic       pixel_en,
  output logic       pix_tick,
  output logic       fetch_req,
  output logic       de,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic [8:0] x,
  output logic [8:0] y,
  output logic       frame_start,
  output logic       busy
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW        = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int TW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int H_SYNC_LO = H_ACTIVE + H_FP;
  localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC;
  localparam int V_SYNC_LO = V_ACTIVE + V_FP;
  localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   start_cnt_q, start_cnt_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic            first_q, first_d;

  logic            pixel_en_q, pixel_en_d;
  logic            pix_tick_q, pix_tick_d;
  logic            fetch_req_q, fetch_req_d;
  logic            de_q, de_d;
  logic            hsync_n_q, hsync_n_d;
  logic            vsync_n_q, vsync_n_d;
  logic [8:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;
  logic            frame_start_q, frame_start_d;
  logic            busy_q, busy_d;

  logic            h_wrap, v_wrap, last_pix;
  logic [HW-1:0]   h_adv, nxt_h;
  logic [VW-1:0]   v_adv, nxt_v;
  logic            nxt_active;
  logic            period_end, fetch_due, frame_done;

  function automatic logic in_range(input int val, input int lo, input int hi);
    return (val >= lo) && (val < hi);
  endfunction

  // Pixel that the next tick enters; the very first tick of a run enters
  // (0,0) itself rather than advancing past it.
  assign h_wrap     = (h_cnt_q == HW'(H_TOTAL - 1));
  assign v_wrap     = (v_cnt_q == VW'(V_TOTAL - 1));
  assign last_pix   = h_wrap && v_wrap;
  assign h_adv      = h_wrap ? '0 : h_cnt_q + HW'(1);
  assign v_adv      = !h_wrap ? v_cnt_q : (v_wrap ? '0 : v_cnt_q + VW'(1));
  assign nxt_h      = first_q ? '0 : h_adv;
  assign nxt_v      = first_q ? '0 : v_adv;
  assign nxt_active = in_range(int'(nxt_h), 0, H_ACTIVE) && in_range(int'(nxt_v), 0, V_ACTIVE);

  assign period_end = (tick_cnt_q == TW'(DIV - 1));
  assign fetch_due  = (tick_cnt_q == TW'(DIV - 2));
  // A drain stops only once the last pixel of the frame has had its full
  // period and the run request is still absent.
  assign frame_done = (state_q == S_DRAIN) && !enable && last_pix && !first_q;

  // State and output registers, cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      start_cnt_q   <= '0;
      tick_cnt_q    <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      first_q       <= 1'b0;
      pixel_en_q    <= 1'b0;
      pix_tick_q    <= 1'b0;
      fetch_req_q   <= 1'b0;
      de_q          <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_cnt_q   <= start_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      first_q       <= first_d;
      pixel_en_q    <= pixel_en_d;
      pix_tick_q    <= pix_tick_d;
      fetch_req_q   <= fetch_req_d;
      de_q          <= de_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state and next-output logic for the run/drain sequencer.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    start_cnt_d   = start_cnt_q;
    tick_cnt_d    = tick_cnt_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    first_d       = first_q;
    pix_tick_d    = 1'b0;
    fetch_req_d   = 1'b0;
    frame_start_d = 1'b0;
    de_d          = de_q;
    hsync_n_d     = hsync_n_q;
    vsync_n_d     = vsync_n_q;
    x_d           = x_q;
    y_d           = y_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_START;
          first_d = 1'b1;
        end
      end

      S_START: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (start_cnt_q == TW'(DIV - 1)) begin
          state_d     = S_RUN;
          start_cnt_d = '0;
        end else begin
          start_cnt_d = start_cnt_q + TW'(1);
        end
      end

      S_RUN, S_DRAIN: begin
        if ((state_q == S_RUN) && !enable) state_d = S_DRAIN;
        if ((state_q == S_DRAIN) && enable) state_d = S_RUN;

        if (period_end && frame_done) begin
          state_d = S_IDLE;
        end else if (period_end) begin
          tick_cnt_d    = '0;
          pix_tick_d    = 1'b1;
          h_cnt_d       = nxt_h;
          v_cnt_d       = nxt_v;
          first_d       = 1'b0;
          frame_start_d = (nxt_h == '0) && (nxt_v == '0);
          de_d          = nxt_active;
          x_d           = nxt_active ? 9'(nxt_h) : 9'd0;
          y_d           = nxt_active ? 9'(nxt_v) : 9'd0;
          hsync_n_d     = !in_range(int'(nxt_h), H_SYNC_LO, H_SYNC_HI);
          vsync_n_d     = !in_range(int'(nxt_v), V_SYNC_LO, V_SYNC_HI);
        end else begin
          tick_cnt_d  = tick_cnt_q + TW'(1);
          // No fetch for a pixel that a finishing drain will never show.
          fetch_req_d = fetch_due && nxt_active && !frame_done;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Anything heading to IDLE returns to the blank, counters-cleared picture.
    if (state_d == S_IDLE) begin
      start_cnt_d = '0;
      tick_cnt_d  = '0;
      h_cnt_d     = '0;
      v_cnt_d     = '0;
      first_d     = 1'b0;
      de_d        = 1'b0;
      x_d         = '0;
      y_d         = '0;
      hsync_n_d   = 1'b1;
      vsync_n_d   = 1'b1;
    end

    pixel_en_d = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  assign pixel_en    = pixel_en_q;
  assign pix_tick    = pix_tick_q;
  assign fetch_req   = fetch_req_q;
  assign de          = de_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule
